cache_controller: RTL and testbench
===================================

Name: cache_controller

Overview:
- Upstream control stage for the direct-mapped write-back cache array, CacheMemory: 2048 lines, one 32-bit word per line, enable-pulse access.
- Accepts word load/store requests from the MIPS datapath and sequences array probes, line fills from main memory, and write-backs of evicted dirty lines.
- Stalls the CPU until each request completes.
- Write policy: write-back, write-allocate.

Parameters:
- TAG_W, 19, tag width = addr[31:13]
- INDEX_W, 11, line index = addr[12:2]
- DATA_W, 32, word width
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  clock
- rst_b  in  1  asynchronous active-low reset
- cpu_req  in  1  request strobe, sampled only in IDLE
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  32  byte address; bits[1:0] ignored
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, valid while cpu_done=1
- cpu_done  out  1  one-cycle completion pulse
- cpu_busy  out  1  high whenever state != IDLE
- cache_enable  out  1  access pulse to array
- cache_we  out  1  array write
- cache_from_mem  out  1  fill write (line clean)
- cache_addr  out  32  array address
- cache_wdata  out  32  array data_in; byte i = bits[8i+7:8i]
- cache_rdata  in  32  array data_out, same packing
- cache_hit  in  1  array hit
- cache_is_evicted  in  1  dirty victim reported
- cache_evicted_tag  in  19  victim tag
- cache_ready  in  1  array access complete
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write
- mem_addr  out  32  word-aligned memory address
- mem_wdata  out  32  write-back data
- mem_rdata  in  32  fill data, valid with mem_ack
- mem_ack  in  1  one-cycle completion; ignored when mem_req=0
- hit_cnt  out  CNT_W  load hits, wraps modulo 2^CNT_W
- miss_cnt  out  CNT_W  load misses, wraps

Behaviour:
- Reset, asynchronous: state=IDLE. Every output is 0, including both counters and cpu_rdata. Array contents are not reset.
- Reset mid-operation: any outstanding memory transaction is abandoned.
- Each state asserts cache_enable for exactly one cycle and holds it low between accesses, so every access produces a fresh posedge for the array.
- States and transitions:
  - IDLE: on cpu_req, latch addr, we and wdata, then go to ACC.
  - ACC: cache_enable=1, cache_we=latched we, from_mem=0, cache_wdata=wdata. Go to EVAL.
  - EVAL: cache_enable=0. Wait while cache_ready=0, then:
    - load hit: rdata<=cache_rdata, hit_cnt++, go to DONE.
    - load miss: miss_cnt++, go to MEM_RD.
    - store with is_evicted: capture victim, go to WB.
    - store without eviction: go to DONE.
  - MEM_RD: mem_req=1, mem_we=0, mem_addr={addr[31:2],2'b00}. On mem_ack, latch mem_rdata and go to FILL.
  - FILL: cache_enable=1, we=1, from_mem=1, wdata=fill word. Go to FEVAL.
  - FEVAL: wait for cache_ready. rdata<=fill word. If is_evicted, capture victim and go to WB; else go to DONE.
  - WB: mem_req=1, mem_we=1. On mem_ack, go to DONE.
  - DONE: cpu_done=1 for one cycle, then IDLE.
- Victim capture: address = {evicted_tag, index, 2'b00}; data = cache_rdata.
- Load-hit latency: request accepted in cycle 0; cpu_done in cycle 3.
- A request asserted on the IDLE cycle after DONE is accepted back-to-back.
- mem_req stays asserted and stable until mem_ack. mem_ack arriving in the same cycle as mem_req rising is legal.
- Counters saturate never: 0xFFFFFFFF+1 = 0.

Decomposition:
- cache_pkg holds: TAG_W, INDEX_W, DATA_W; the state enum; tag/index extraction functions; victim-address build function.
- One sub-module, cache_stat_counters: the two wrap-around counters with increment strobes.

Test Plan:
- Load 0x0000_2004 into an empty cache -> mem read at 0x0000_2004. Return 0xCAFEBABE -> FILL with from_mem=1, cpu_rdata=0xCAFEBABE, miss_cnt=1, no WB.
- Repeat the load -> cpu_done 3 cycles after acceptance, no mem_req, hit_cnt=1.
- Store 0x11223344 to 0x0000_0010, then store to 0x0000_2010 (same index 4, different tag) -> second store triggers WB to 0x0000_0010 with data 0x11223344.
- Dirty line at 0x0000_0010, then load 0x0000_2010 -> MEM_RD, then FILL reports eviction, then WB to 0x0000_0010. cpu_done only after the WB ack.
- mem_ack delayed 7 cycles -> mem_req/addr stable for all 7, cpu_busy=1 throughout. Spurious mem_ack in IDLE -> no effect.
- rst_b low during MEM_RD -> immediate IDLE, all outputs 0. A following load of the same address misses again.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: widths, controller state encoding and tag/index/victim-address helpers shared by the cache controller files
package cache_pkg;
  localparam int TAG_W = 19;
  localparam int INDEX_W = 11;
  localparam int DATA_W = 32;
  typedef enum logic [2:0] {IDLE, ACC, EVAL, MEM_RD, FILL, FEVAL, WB, DONE} state_t;
  function automatic logic [TAG_W-1:0] get_tag(input logic [31:0] addr);
    return addr[31:13];
  endfunction
  function automatic logic [INDEX_W-1:0] get_index(input logic [31:0] addr);
    return addr[12:2];
  endfunction
  function automatic logic [31:0] victim_addr(input logic [TAG_W-1:0] tag, input logic [INDEX_W-1:0] index);
    return {tag, index, 2'b00};
  endfunction
endpackage

// File: rtl/cache_stat_counters.sv
// cache_stat_counters: wrap-around load hit/miss counters (clk, rst_b, hit_inc/miss_inc strobes in; hit_cnt/miss_cnt out)
module cache_stat_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             hit_inc,
  input  logic             miss_inc,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      hit_cnt <= hit_cnt + CNT_W'(hit_inc);
      miss_cnt <= miss_cnt + CNT_W'(miss_inc);
    end
endmodule

// File: rtl/cache_controller.sv
// cache_controller: write-back/write-allocate sequencer between the CPU (cpu_*), the direct-mapped array (cache_*) and main memory (mem_*), with hit/miss counters
module cache_controller
  import cache_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_busy,
  output logic              cache_enable,
  output logic              cache_we,
  output logic              cache_from_mem,
  output logic [31:0]       cache_addr,
  output logic [DATA_W-1:0] cache_wdata,
  input  logic [DATA_W-1:0] cache_rdata,
  input  logic              cache_hit,
  input  logic              cache_is_evicted,
  input  logic [TAG_W-1:0]  cache_evicted_tag,
  input  logic              cache_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  state_t state, state_nx;
  logic [31:0] a_addr, v_addr;
  logic a_we, hit_inc, miss_inc, cap_victim;
  logic [DATA_W-1:0] a_wdata, fill, v_data, rdata;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      state <= IDLE;
      a_addr <= '0;
      a_we <= 1'b0;
      a_wdata <= '0;
      fill <= '0;
      v_addr <= '0;
      v_data <= '0;
      rdata <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cpu_req) begin
        a_addr <= cpu_addr;
        a_we <= cpu_we;
        a_wdata <= cpu_wdata;
      end
      if (state == MEM_RD && mem_ack) fill <= mem_rdata;
      if (hit_inc) rdata <= cache_rdata;
      if (state == FEVAL && cache_ready) rdata <= fill;
      if (cap_victim) begin
        v_addr <= victim_addr(cache_evicted_tag, get_index(a_addr));
        v_data <= cache_rdata;
      end
    end
  always_comb begin
    state_nx = state;
    hit_inc = 1'b0;
    miss_inc = 1'b0;
    cap_victim = 1'b0;
    case (state)
      IDLE:   state_nx = cpu_req ? ACC : IDLE;
      ACC:    state_nx = EVAL;
      EVAL:   if (cache_ready) begin
        hit_inc = !a_we && cache_hit;
        miss_inc = !a_we && !cache_hit;
        cap_victim = a_we && cache_is_evicted;
        state_nx = miss_inc ? MEM_RD : cap_victim ? WB : DONE;
      end
      MEM_RD: state_nx = mem_ack ? FILL : MEM_RD;
      FILL:   state_nx = FEVAL;
      FEVAL:  if (cache_ready) begin
        cap_victim = cache_is_evicted;
        state_nx = cache_is_evicted ? WB : DONE;
      end
      WB:     state_nx = mem_ack ? DONE : WB;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  assign cpu_rdata = rdata;
  assign cpu_done = state == DONE;
  assign cpu_busy = state != IDLE;
  assign cache_enable = state == ACC || state == FILL;
  assign cache_we = state == FILL || (state == ACC && a_we);
  assign cache_from_mem = state == FILL;
  assign cache_addr = a_addr;
  assign cache_wdata = state == FILL ? fill : a_wdata;
  assign mem_req = state == MEM_RD || state == WB;
  assign mem_we = state == WB;
  assign mem_addr = state == WB ? v_addr : {a_addr[31:2], 2'b00};
  assign mem_wdata = v_data;
  cache_stat_counters #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .rst_b(rst_b),
    .hit_inc(hit_inc),
    .miss_inc(miss_inc),
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: scoreboard bench with array/memory responders and a cache-semantics reference model
module tb_cache_controller;
  logic clk = 0, rst_b = 0;
  always #5 clk = ~clk;
  logic cpu_req = 0, cpu_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic [31:0] cpu_rdata;
  logic cpu_done, cpu_busy;
  logic cache_enable, cache_we, cache_from_mem;
  logic [31:0] cache_addr, cache_wdata;
  logic [31:0] cache_rdata = 0;
  logic cache_hit = 0, cache_is_evicted = 0, cache_ready = 0;
  logic [18:0] cache_evicted_tag = 0;
  logic mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic resp_ack = 0, spur_ack = 0;
  logic [31:0] hit_cnt, miss_cnt;
  assign mem_ack = resp_ack | spur_ack;
  cache_controller dut (
    .clk(clk), .rst_b(rst_b),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_busy(cpu_busy),
    .cache_enable(cache_enable), .cache_we(cache_we), .cache_from_mem(cache_from_mem),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_rdata(cache_rdata),
    .cache_hit(cache_hit), .cache_is_evicted(cache_is_evicted),
    .cache_evicted_tag(cache_evicted_tag), .cache_ready(cache_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );
  int tests = 0, fails = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  logic [31:0] mm [logic [31:0]];
  logic [31:0] arch [logic [31:0]];
  function automatic logic [31:0] mm_rd(input logic [31:0] a);
    return mm.exists(a) ? mm[a] : a ^ 32'h9E37_79B9;
  endfunction
  function automatic logic [31:0] arch_rd(input logic [31:0] a);
    return arch.exists(a) ? arch[a] : a ^ 32'h9E37_79B9;
  endfunction
  logic av [2048];
  logic ad [2048];
  logic [18:0] at [2048];
  logic [31:0] adata [2048];
  int arr_lat = 0, n_fill = 0;
  initial begin
    int ix;
    logic [18:0] tg;
    for (int i = 0; i < 2048; i++) begin
      av[i] = 0; ad[i] = 0; at[i] = 0; adata[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (cache_enable) begin
        ix = int'(cache_addr[12:2]);
        tg = cache_addr[31:13];
        cache_hit = av[ix] && at[ix] == tg;
        cache_rdata = adata[ix];
        cache_evicted_tag = at[ix];
        cache_is_evicted = cache_we && av[ix] && ad[ix] && at[ix] != tg;
        if (cache_we) begin
          av[ix] = 1; at[ix] = tg; adata[ix] = cache_wdata; ad[ix] = !cache_from_mem;
        end
        if (cache_from_mem) n_fill++;
        cache_ready = 0;
        repeat (arr_lat) @(negedge clk);
        cache_ready = 1;
      end
    end
  end
  logic mv [2048];
  logic md [2048];
  logic [18:0] mt [2048];
  logic [31:0] m_hits = 0, m_miss = 0;
  typedef struct packed {logic ld; logic [31:0] rd; logic [31:0] hc; logic [31:0] mc;} cexp_t;
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} mexp_t;
  cexp_t cq[$];
  mexp_t mq[$];
  task automatic model_issue(input logic we, input logic [31:0] a, input logic [31:0] wd);
    logic [10:0] ix;
    logic [18:0] tg;
    logic [31:0] wa, victim;
    logic hit, evict;
    ix = a[12:2];
    tg = a[31:13];
    wa = {a[31:2], 2'b00};
    hit = mv[ix] && mt[ix] == tg;
    evict = !hit && mv[ix] && md[ix];
    victim = {mt[ix], ix, 2'b00};
    if (!we) begin
      if (hit) m_hits++;
      else begin
        m_miss++;
        mq.push_back('{1'b0, wa, 32'h0});
        if (evict) mq.push_back('{1'b1, victim, arch_rd(victim)});
        mv[ix] = 1; mt[ix] = tg; md[ix] = 0;
      end
      cq.push_back('{1'b1, arch_rd(wa), m_hits, m_miss});
    end else begin
      if (evict) mq.push_back('{1'b1, victim, arch_rd(victim)});
      mv[ix] = 1; mt[ix] = tg; md[ix] = 1;
      arch[wa] = wd;
      cq.push_back('{1'b0, 32'h0, m_hits, m_miss});
    end
  endtask
  initial begin
    cexp_t e;
    forever begin
      @(negedge clk);
      if (cpu_done) begin
        if (cq.size() == 0) check("unexpected_cpu_done", 1, 0);
        else begin
          e = cq.pop_front();
          if (e.ld) check("load_rdata", cpu_rdata, e.rd);
          check("hit_cnt", hit_cnt, e.hc);
          check("miss_cnt", miss_cnt, e.mc);
        end
      end
    end
  end
  int mem_lat = 0, n_rd = 0, n_wb = 0;
  logic [31:0] last_wb_addr = 0, last_wb_data = 0;
  initial begin
    mexp_t m;
    logic [31:0] ra, rdat;
    logic rw, okst, aborted;
    int d;
    forever begin
      @(negedge clk);
      if (rst_b && mem_req) begin
        ra = mem_addr; rw = mem_we; rdat = mem_wdata; okst = 1; aborted = 0;
        if (mq.size() == 0) check("unexpected_mem_req", 1, 0);
        else begin
          m = mq.pop_front();
          check("mem_we", 32'(rw), 32'(m.we));
          check("mem_addr", ra, m.addr);
          if (m.we) check("mem_wdata", rdat, m.data);
        end
        d = mem_lat;
        for (int k = 0; k < d; k++) begin
          @(negedge clk);
          if (!rst_b) begin
            aborted = 1;
            break;
          end
          if (!(mem_req && mem_addr == ra && mem_we == rw && mem_wdata == rdat && cpu_busy)) okst = 0;
        end
        if (d > 0 && !aborted) check("mem_req_stable", 32'(okst), 1);
        if (!aborted) begin
          mem_rdata = rw ? 32'h0 : mm_rd(ra);
          if (rw) begin
            mm[ra] = rdat; n_wb++; last_wb_addr = ra; last_wb_data = rdat;
          end else n_rd++;
          resp_ack = 1;
          @(negedge clk);
          resp_ack = 0;
          mem_rdata = $urandom;
        end
      end
    end
  end
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd, output int lat);
    logic busy_ok;
    @(negedge clk);
    model_issue(we, a, wd);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    @(posedge clk);
    #1 cpu_req = 0;
    lat = 0;
    busy_ok = 1;
    while (lat < 500) begin
      @(negedge clk);
      lat++;
      if (!cpu_busy) busy_ok = 0;
      if (cpu_done) break;
    end
    check("req_completes", 32'(cpu_done), 1);
    check("busy_until_done", 32'(busy_ok), 1);
  endtask
  function automatic logic outs_nonzero();
    return |{cpu_rdata, cpu_done, cpu_busy, cache_enable, cache_we, cache_from_mem, cache_addr,
             cache_wdata, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt};
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int lat, k, f0, r0, w0;
    logic [10:0] ix;
    logic sv, sd;
    logic [18:0] st;
    logic [31:0] a;
    for (int i = 0; i < 2048; i++) begin
      mv[i] = 0; md[i] = 0; mt[i] = 0;
    end
    mm[32'h0000_2004] = 32'hCAFE_BABE;
    arch[32'h0000_2004] = 32'hCAFE_BABE;
    repeat (3) @(negedge clk);
    check("reset_outputs_zero", 32'(outs_nonzero()), 0);
    rst_b = 1;
    f0 = n_fill; r0 = n_rd; w0 = n_wb;
    do_req(0, 32'h0000_2004, 0, lat);
    check("miss_rdata", cpu_rdata, 32'hCAFE_BABE);
    check("miss_one_fill", 32'(n_fill - f0), 1);
    check("miss_one_read", 32'(n_rd - r0), 1);
    check("miss_no_wb", 32'(n_wb - w0), 0);
    r0 = n_rd;
    do_req(0, 32'h0000_2004, 0, lat);
    check("hit_latency", 32'(lat), 3);
    check("hit_no_mem", 32'(n_rd - r0), 0);
    check("hit_cnt_direct", hit_cnt, 1);
    do_req(1, 32'h0000_0010, 32'h1122_3344, lat);
    w0 = n_wb;
    do_req(1, 32'h0000_2010, 32'hAABB_CCDD, lat);
    check("store_evict_wb", 32'(n_wb - w0), 1);
    check("store_evict_addr", last_wb_addr, 32'h0000_0010);
    check("store_evict_data", last_wb_data, 32'h1122_3344);
    do_req(1, 32'h0000_0010, 32'h5566_7788, lat);
    r0 = n_rd; w0 = n_wb;
    do_req(0, 32'h0000_2010, 0, lat);
    check("fill_evict_read", 32'(n_rd - r0), 1);
    check("fill_evict_wb_before_done", 32'(n_wb - w0), 1);
    check("fill_evict_addr", last_wb_addr, 32'h0000_0010);
    check("fill_evict_data", last_wb_data, 32'h5566_7788);
    check("fill_evict_rdata", cpu_rdata, 32'hAABB_CCDD);
    mem_lat = 7;
    do_req(0, 32'h0000_8000, 0, lat);
    check("slow_mem_latency", 32'(lat >= 10), 1);
    @(negedge clk);
    spur_ack = 1;
    @(negedge clk);
    spur_ack = 0;
    check("spurious_ack_idle", 32'(cpu_busy | mem_req | cpu_done), 0);
    check("spurious_ack_hits", hit_cnt, m_hits);
    check("spurious_ack_misses", miss_cnt, m_miss);
    a = 32'h0000_4008;
    ix = a[12:2];
    sv = mv[ix]; st = mt[ix]; sd = md[ix];
    @(negedge clk);
    model_issue(0, a, 0);
    cpu_req = 1; cpu_we = 0; cpu_addr = a;
    @(posedge clk);
    #1 cpu_req = 0;
    k = 0;
    while (!mem_req && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("reset_test_in_mem_rd", 32'(mem_req), 1);
    @(negedge clk);
    #2 rst_b = 0;
    #1 check("reset_mid_op_outputs_zero", 32'(outs_nonzero()), 0);
    @(negedge clk);
    #2 rst_b = 1;
    cq.delete();
    mq.delete();
    mv[ix] = sv; mt[ix] = st; md[ix] = sd;
    m_hits = 0; m_miss = 0;
    r0 = n_rd;
    do_req(0, a, 0, lat);
    check("after_reset_misses_again", 32'(n_rd - r0), 1);
    check("after_reset_miss_cnt", miss_cnt, 1);
    for (int i = 0; i < 300; i++) begin
      mem_lat = $urandom_range(0, 3);
      arr_lat = $urandom_range(0, 2);
      a = ($urandom_range(0, 3) << 13) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      do_req(1'($urandom_range(0, 1)), a, $urandom, lat);
    end
    repeat (5) @(negedge clk);
    check("cpu_queue_drained", 32'(cq.size()), 0);
    check("mem_queue_drained", 32'(mq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
